// File: rtl/pio_pkg.sv
// Shared definitions for the PIO shift-register controllers (OSR now, ISR later).
// Latency: none (declarations only); backpressure: n/a.
package pio_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        READY      = 2'd0,
        STALL_OUT  = 2'd1,
        STALL_PULL = 2'd2
    } osr_state_e;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;
endpackage

// File: rtl/pio_shift_unit.sv
// Combinational barrel shifter: shifts word by n (1..DATA_W) and returns the bits shifted out, right-justified.
// Latency: 0 cycles; backpressure: none.
module pio_shift_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic [DATA_W-1:0] word,
    input  logic [CNT_W-1:0]  n,
    input  logic              dir,
    output logic [DATA_W-1:0] shifted,
    output logic [DATA_W-1:0] extracted
);
    import pio_pkg::*;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

    // A shift amount equal to DATA_W yields zero, so n=32 needs no special case.
    always_comb begin
        shifted   = '0;
        extracted = '0;
        if (dir == SHIFT_RIGHT) begin
            shifted   = word >> n;
            extracted = word & ({DATA_W{1'b1}} >> (FULL - n));
        end else begin
            shifted   = word << n;
            extracted = word >> (FULL - n);
        end
    end
endmodule

// File: rtl/pio_osr_ctrl.sv
// OSR controller: sequences OUT/PULL, autopull refill from the TX FIFO, stalls the sequencer on an empty FIFO.
// Latency: out_data/out_valid one cycle after completion; backpressure: stall held combinationally while the FIFO is empty.
module pio_osr_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              exec_out,
    input  logic              exec_pull,
    input  logic [4:0]        bit_count,
    input  logic              pull_block,
    input  logic              pull_ifempty,
    input  logic              shift_dir,
    input  logic              autopull_en,
    input  logic [4:0]        pull_thresh,
    input  logic [DATA_W-1:0] x_in,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_pop,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  osr_count
);
    import pio_pkg::*;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);

    osr_state_e        state_q, state_d;
    logic [DATA_W-1:0] osr_q, osr_d;
    logic [CNT_W-1:0]  osr_count_q, osr_count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [CNT_W-1:0]  n_eff, thresh_eff, count_sat;
    logic [CNT_W:0]    count_sum;
    logic              need_refill, pop_c, stall_c;
    logic [DATA_W-1:0] sh_word, sh_shifted, sh_extracted;

    assign n_eff       = (bit_count == 5'd0) ? FULL : CNT_W'(bit_count);
    assign thresh_eff  = (pull_thresh == 5'd0) ? FULL : CNT_W'(pull_thresh);
    assign need_refill = autopull_en && (osr_count_q >= thresh_eff);
    assign count_sum   = {1'b0, osr_count_q} + {1'b0, n_eff};
    assign count_sat   = (count_sum > {1'b0, FULL}) ? FULL : count_sum[CNT_W-1:0];

    // A refilling OUT shifts the FIFO head directly, so the word never sits in the OSR unshifted.
    assign sh_word = (state_q == STALL_OUT || need_refill) ? fifo_rdata : osr_q;

    pio_shift_unit #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shift (
        .word      (sh_word),
        .n         (n_eff),
        .dir       (shift_dir),
        .shifted   (sh_shifted),
        .extracted (sh_extracted)
    );

    always_comb begin
        state_d     = state_q;
        osr_d       = osr_q;
        osr_count_d = osr_count_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        pop_c       = 1'b0;
        stall_c     = 1'b0;
        case (state_q)
            READY: begin
                if (exec_out) begin
                    if (!need_refill) begin
                        osr_d       = sh_shifted;
                        osr_count_d = count_sat;
                        out_data_d  = sh_extracted;
                        out_valid_d = 1'b1;
                    end else if (!fifo_empty) begin
                        pop_c       = 1'b1;
                        osr_d       = sh_shifted;
                        osr_count_d = n_eff;
                        out_data_d  = sh_extracted;
                        out_valid_d = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = STALL_OUT;
                    end
                end else if (exec_pull) begin
                    if (!(pull_ifempty && (osr_count_q < thresh_eff))) begin
                        if (!fifo_empty) begin
                            pop_c       = 1'b1;
                            osr_d       = fifo_rdata;
                            osr_count_d = '0;
                        end else if (pull_block) begin
                            stall_c = 1'b1;
                            state_d = STALL_PULL;
                        end else begin
                            osr_d       = x_in;
                            osr_count_d = '0;
                        end
                    end
                end else if (need_refill && !fifo_empty) begin
                    pop_c       = 1'b1;
                    osr_d       = fifo_rdata;
                    osr_count_d = '0;
                end
            end
            STALL_OUT: begin
                if (fifo_empty) begin
                    stall_c = 1'b1;
                end else begin
                    pop_c       = 1'b1;
                    osr_d       = sh_shifted;
                    osr_count_d = n_eff;
                    out_data_d  = sh_extracted;
                    out_valid_d = 1'b1;
                    state_d     = READY;
                end
            end
            STALL_PULL: begin
                if (fifo_empty) begin
                    stall_c = 1'b1;
                end else begin
                    pop_c       = 1'b1;
                    osr_d       = fifo_rdata;
                    osr_count_d = '0;
                    state_d     = READY;
                end
            end
            default: state_d = READY;
        endcase
    end

    // Reset must never let a pop or stall escape while the registers are being cleared.
    assign fifo_pop  = pop_c && reset_n;
    assign stall     = stall_c && reset_n;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign osr_count = osr_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= READY;
            osr_q       <= '0;
            osr_count_q <= FULL;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            osr_q       <= osr_d;
            osr_count_q <= osr_count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_pio_osr_ctrl.sv
// Bench for pio_osr_ctrl: directed test-plan scenarios then randomized instructions against a behavioural model.
module tb_pio_osr_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        exec_out, exec_pull;
    logic [4:0]  bit_count, pull_thresh;
    logic        pull_block, pull_ifempty, shift_dir, autopull_en;
    logic [31:0] x_in, fifo_rdata;
    logic        fifo_empty;
    logic        fifo_pop, out_valid, stall;
    logic [31:0] out_data;
    logic [5:0]  osr_count;

    always #5 clk = ~clk;

    pio_osr_ctrl dut (
        .clk(clk), .reset_n(reset_n), .exec_out(exec_out), .exec_pull(exec_pull),
        .bit_count(bit_count), .pull_block(pull_block), .pull_ifempty(pull_ifempty),
        .shift_dir(shift_dir), .autopull_en(autopull_en), .pull_thresh(pull_thresh),
        .x_in(x_in), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_pop(fifo_pop),
        .out_data(out_data), .out_valid(out_valid), .stall(stall), .osr_count(osr_count)
    );

    logic [31:0] q[$];
    bit          pop_pending;
    bit          rand_push;
    int          n_pops;
    int          n_checks;
    int          n_errors;

    // Model state: what the DUT registers must hold during the current cycle.
    logic [31:0] m_osr, m_od;
    int          m_cnt;
    bit          m_ov, m_stall_cur;
    bit          prev_stall, prev_eo, prev_ep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mshift(input logic [31:0] w, input int n, input bit right,
                                   output logic [31:0] ext, output logic [31:0] rem);
        logic [63:0] wide;
        wide = {32'h0, w};
        if (right) begin
            ext = w & 32'((64'd1 << n) - 64'd1);
            rem = 32'(wide >> n);
        end else begin
            ext = 32'(wide >> (32 - n));
            rem = 32'(wide << n);
        end
    endfunction

    task automatic fifo_drive();
        fifo_empty = (q.size() == 0);
        fifo_rdata = fifo_empty ? $urandom : q[0];
    endtask

    task automatic push(input logic [31:0] v);
        q.push_back(v);
        fifo_drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_pending && q.size() > 0) void'(q.pop_front());
        if (rand_push && q.size() < 8 && $urandom_range(0, 3) == 0) q.push_back($urandom);
        fifo_drive();
    endtask

    // Compare process: checks every cycle, then advances the model by the rules.
    logic [31:0] e_ext, e_rem, n_osr, n_od;
    int          e_n, e_th, n_cnt;
    bit          e_need, e_pop, e_stall, n_ov;
    always @(negedge clk) begin
        if (!reset_n) begin
            m_osr = 32'h0; m_od = 32'h0; m_cnt = 32; m_ov = 1'b0;
            chk("rst_stall", {31'h0, stall}, 32'h0);
            chk("rst_pop", {31'h0, fifo_pop}, 32'h0);
            chk("rst_count", {26'h0, osr_count}, 32'd32);
            chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
            chk("rst_out_data", out_data, 32'h0);
            m_stall_cur = 1'b0;
            pop_pending = 1'b0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall)
                assert (exec_out == prev_eo && exec_pull == prev_ep)
                else $error("exec_* dropped while stalled at %0t", $time);
            chk("osr_count", {26'h0, osr_count}, 32'(m_cnt));
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_ov});
            if (m_ov) chk("out_data", out_data, m_od);

            e_n    = (bit_count == 5'd0) ? 32 : int'(bit_count);
            e_th   = (pull_thresh == 5'd0) ? 32 : int'(pull_thresh);
            e_need = autopull_en && (m_cnt >= e_th);
            e_pop = 1'b0; e_stall = 1'b0; n_ov = 1'b0;
            n_osr = m_osr; n_od = m_od; n_cnt = m_cnt;
            if (exec_out) begin
                if (!e_need) begin
                    mshift(m_osr, e_n, shift_dir, e_ext, e_rem);
                    n_osr = e_rem; n_od = e_ext; n_ov = 1'b1;
                    n_cnt = (m_cnt + e_n > 32) ? 32 : m_cnt + e_n;
                end else if (!fifo_empty) begin
                    mshift(fifo_rdata, e_n, shift_dir, e_ext, e_rem);
                    e_pop = 1'b1; n_osr = e_rem; n_od = e_ext; n_ov = 1'b1; n_cnt = e_n;
                end else begin
                    e_stall = 1'b1;
                end
            end else if (exec_pull) begin
                if (pull_ifempty && m_cnt < e_th) begin
                    n_cnt = m_cnt;
                end else if (!fifo_empty) begin
                    e_pop = 1'b1; n_osr = fifo_rdata; n_cnt = 0;
                end else if (pull_block) begin
                    e_stall = 1'b1;
                end else begin
                    n_osr = x_in; n_cnt = 0;
                end
            end else if (e_need && !fifo_empty) begin
                e_pop = 1'b1; n_osr = fifo_rdata; n_cnt = 0;
            end
            chk("stall", {31'h0, stall}, {31'h0, e_stall});
            chk("fifo_pop", {31'h0, fifo_pop}, {31'h0, e_pop});

            pop_pending = fifo_pop;
            if (fifo_pop) n_pops++;
            m_stall_cur = e_stall;
            prev_stall = stall; prev_eo = exec_out; prev_ep = exec_pull;
            m_osr = n_osr; m_od = n_od; m_cnt = n_cnt; m_ov = n_ov;
        end
    end

    // Drive one instruction and hold it until the model says it completes.
    task automatic issue(input bit eo, input bit ep, input logic [4:0] bc,
                         input int push_after, input logic [31:0] pv, output int sc);
        bit done;
        done = 1'b0;
        exec_out = eo; exec_pull = ep; bit_count = bc;
        sc = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (!m_stall_cur) begin
                done = 1'b1;
                break;
            end
            sc++;
            step();
            if (sc == push_after) push(pv);
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout: stalled %0d cycles, required completion", sc);
        end
        step();
        exec_out = 1'b0; exec_pull = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input int cnt);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h1);
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_count"}, {26'h0, osr_count}, 32'(cnt));
        step();
    endtask

    task automatic expect_cnt(input string tag, input int cnt);
        @(negedge clk);
        #1;
        chk({tag, "_count"}, {26'h0, osr_count}, 32'(cnt));
        step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exec_out = 1'b0; exec_pull = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int sc, p0, op;
    initial begin
        n_checks = 0; n_errors = 0; n_pops = 0;
        rand_push = 1'b0; pop_pending = 1'b0;
        reset_n = 1'b0; exec_out = 1'b0; exec_pull = 1'b0; bit_count = 5'd0;
        pull_block = 1'b1; pull_ifempty = 1'b0; shift_dir = 1'b1; autopull_en = 1'b0;
        pull_thresh = 5'd0; x_in = 32'h0;
        fifo_drive();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();

        // PULL 0xDEADBEEF then OUT 8 right.
        push(32'hDEADBEEF);
        p0 = n_pops;
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t1_pull", 0);
        issue(1'b1, 1'b0, 5'd8, -1, 32'h0, sc);
        expect_out("t1_out8r", 32'h000000EF, 8);
        chk("t1_pops", 32'(n_pops - p0), 32'd1);
        issue(1'b1, 1'b0, 5'd0, -1, 32'h0, sc);
        expect_out("t1_rest", 32'h00DEADBE, 32);

        // Same load, OUT 4 left.
        shift_dir = 1'b0;
        push(32'hDEADBEEF);
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t2_pull", 0);
        issue(1'b1, 1'b0, 5'd4, -1, 32'h0, sc);
        expect_out("t2_out4l", 32'h0000000D, 4);
        issue(1'b1, 1'b0, 5'd0, -1, 32'h0, sc);
        expect_out("t2_rest", 32'hEADBEEF0, 32);

        // Autopull at thresh 32 on an empty FIFO: OUT stalls until a push.
        do_reset();
        autopull_en = 1'b1; pull_thresh = 5'd0; shift_dir = 1'b1;
        p0 = n_pops;
        issue(1'b1, 1'b0, 5'd16, 3, 32'h12345678, sc);
        chk("t3_stall_cycles", 32'(sc), 32'd3);
        expect_out("t3_autopull", 32'h00005678, 16);
        chk("t3_pops", 32'(n_pops - p0), 32'd1);
        autopull_en = 1'b0;

        // Blocking PULL on an empty FIFO, then reset mid-stall.
        pull_block = 1'b0; x_in = 32'h0;
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t4_xload", 0);
        pull_block = 1'b1;
        exec_pull = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("t4_stall_held", {31'h0, stall}, 32'h1);
            step();
        end
        reset_n = 1'b0; exec_pull = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_rst_count", {26'h0, osr_count}, 32'd32);
        chk("t4_rst_stall", {31'h0, stall}, 32'h0);
        chk("t4_rst_pop", {31'h0, fifo_pop}, 32'h0);
        step();
        reset_n = 1'b1;
        step();

        // Non-blocking PULL loads X; OUT 32 returns it whole.
        pull_block = 1'b0; x_in = 32'hA5A5A5A5;
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t5_xload", 0);
        issue(1'b1, 1'b0, 5'd0, -1, 32'h0, sc);
        expect_out("t5_out32", 32'hA5A5A5A5, 32);

        // Counter saturation, then PULL ifempty below threshold.
        x_in = 32'h0;
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t6_load", 0);
        issue(1'b1, 1'b0, 5'd28, -1, 32'h0, sc);
        expect_out("t6_out28", 32'h0, 28);
        issue(1'b1, 1'b0, 5'd8, -1, 32'h0, sc);
        expect_out("t6_sat", 32'h0, 32);
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t6_reload", 0);
        issue(1'b1, 1'b0, 5'd4, -1, 32'h0, sc);
        expect_out("t6_out4", 32'h0, 4);
        pull_thresh = 5'd8; pull_ifempty = 1'b1;
        push(32'hCAFEF00D);
        p0 = n_pops;
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t6_ifempty_noop", 4);
        chk("t6_ifempty_pops", 32'(n_pops - p0), 32'd0);
        pull_ifempty = 1'b0;
        issue(1'b0, 1'b1, 5'd0, -1, 32'h0, sc);
        expect_cnt("t6_drain", 0);

        // Randomized instruction mix with random FIFO pushes.
        rand_push = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            autopull_en  = ($urandom_range(0, 1) == 1);
            pull_thresh  = 5'($urandom);
            shift_dir    = ($urandom_range(0, 1) == 1);
            pull_block   = ($urandom_range(0, 1) == 1);
            pull_ifempty = ($urandom_range(0, 3) == 0);
            x_in         = $urandom;
            op = $urandom_range(0, 4);
            case (op)
                0, 1: issue(1'b1, 1'b0, 5'($urandom), -1, 32'h0, sc);
                2:    issue(1'b0, 1'b1, 5'($urandom), -1, 32'h0, sc);
                3:    issue(1'b1, 1'b1, 5'($urandom), -1, 32'h0, sc);
                default: begin
                    exec_out = 1'b0; exec_pull = 1'b0;
                    repeat ($urandom_range(1, 3)) step();
                end
            endcase
        end
        rand_push = 1'b0;
        exec_out = 1'b0; exec_pull = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pio_osr_ctrl.md
# pio_osr_ctrl

Output-shift-register controller for one PIO state machine. It owns the 32-bit OSR and its shift counter, and sequences OUT and PULL instructions from the state-machine sequencer. It refills the OSR from the TX FIFO explicitly (PULL) or by autopull at a programmable threshold, and raises a stall toward the sequencer whenever an instruction cannot complete. It sits between the TX FIFO read port and the OUT-destination mux.

## Interface
Parameters:
- DATA_W, 32, OSR and FIFO word width; the block supports 32 only.
- CNT_W, 6, shift-counter width, holding 0..32.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- exec_out  in  1  OUT instruction present; held by the sequencer while stall=1.
- exec_pull  in  1  PULL instruction present; held while stall=1.
- bit_count  in  5  OUT bit count; 0 means 32.
- pull_block  in  1  PULL blocks when the FIFO is empty.
- pull_ifempty  in  1  PULL is a no-op unless the counter is at or above the threshold.
- shift_dir  in  1  1 = shift right (LSB first), 0 = shift left.
- autopull_en  in  1  enables autopull.
- pull_thresh  in  5  autopull threshold; 0 means 32.
- x_in  in  32  X register value, loaded by a non-blocking PULL when the FIFO is empty.
- fifo_empty  in  1  TX FIFO empty.
- fifo_rdata  in  32  TX FIFO head, show-ahead.
- fifo_pop  out  1  combinational; the FIFO advances on the same edge.
- out_data  out  32  shifted-out bits, right-justified, registered.
- out_valid  out  1  one-cycle pulse qualifying out_data.
- stall  out  1  combinational; the instruction did not complete this cycle.
- osr_count  out  6  current shift count; 32 means empty.

## Operation
- Reset values: osr=0, osr_count=32, out_data=0, out_valid=0, fifo_pop=0, stall=0, state READY.
- Effective n = (bit_count==0) ? 32 : bit_count. Effective thresh is derived the same way.
- Shift rules:
  - Right shift: extracted bits = osr[n-1:0]; osr <= osr >> n.
  - Left shift: extracted bits = osr[31:32-n]; osr <= osr << n.
  - n=32: extracted bits = osr; osr <= 0.
  - Count update: osr_count <= min(osr_count+n, 32), saturating.
- need_refill = autopull_en && osr_count >= thresh.
- Precedence: exec_out wins over exec_pull if both are asserted; the PULL is ignored that cycle.
- State READY:
  - OUT with !need_refill: shift the current osr; out_valid next cycle.
  - OUT with need_refill and !fifo_empty: assert fifo_pop. Apply the shift to fifo_rdata in the same cycle; the result goes to osr, osr_count <= n.
  - OUT with need_refill and fifo_empty: assert stall; go to STALL_OUT.
  - PULL with pull_ifempty && osr_count < thresh: no-op, completes with no pop.
  - PULL otherwise, FIFO non-empty: pop, osr <= fifo_rdata, osr_count <= 0.
  - PULL, FIFO empty, pull_block=1: stall; go to STALL_PULL.
  - PULL, FIFO empty, pull_block=0: osr <= x_in, osr_count <= 0.
  - Idle cycle with need_refill and !fifo_empty: background refill (pop, load, count <= 0).
- STALL_OUT: stall=1 while fifo_empty. On the first non-empty cycle, perform the combined refill+OUT with stall=0, then return to READY.
- STALL_PULL: stall=1 while fifo_empty. On the first non-empty cycle, pop and load with stall=0, then return to READY.
- Configuration inputs are static while state != READY.
- Deassertion of exec_* during a stall is illegal. The bench flags it with an assertion.
- reset_n low in any state: immediate return to reset values. No pop is issued.

## Timing
- OUT latency: out_data/out_valid are registered one cycle after the completing edge.
- fifo_pop is asserted only in the cycle that consumes fifo_rdata. At most one pop per cycle.
- An instruction completes in the cycle where exec_* is high and stall=0. Minimum one cycle; a stall adds one cycle per empty-FIFO cycle.
- A background refill occupies only idle cycles. It never delays an instruction.

## Structure
- Shared package pio_pkg holds:
  - DATA_W and CNT_W constants;
  - the osr_state_e enum {READY, STALL_OUT, STALL_PULL};
  - the shift_dir encoding constants.
- One sub-module, pio_shift_unit: a combinational barrel shifter. Inputs are word, n and dir; outputs are the shifted word and the right-justified extracted bits. It is reused by the future ISR controller.

## Test plan
- Reset, then PULL with FIFO head 0xDEADBEEF, then OUT n=8 right → pop once; out_data=0x000000EF; osr_count=8; osr=0x00DEADBE.
- Same load, OUT n=4 left → out_data=0x0000000D; osr=0xEADBEEF0.
- Autopull with thresh=32 after reset, FIFO empty → OUT stalls 3 cycles. Push 0x12345678, OUT n=16 right → out_data=0x5678, osr_count=16, exactly one pop.
- Blocking PULL on an empty FIFO → stall held. Pulse reset_n mid-stall → osr_count=32, stall=0, fifo_pop=0.
- Non-blocking PULL, empty FIFO, x_in=0xA5A5A5A5 → osr=0xA5A5A5A5, count 0. OUT n=0 (32 bits) → out_data=0xA5A5A5A5, count 32.
- Counter saturation at count=28 with OUT n=8 → count 32. PULL with pull_ifempty, count=4, thresh=8 → no-op, no pop.
